// File: rtl/count_capture_if.sv
// count_capture_if: snapshot read handshake
// Carries the read-side valid/ready/data bundle of count_capture.
interface count_capture_if #(
  parameter int W = 16
);
  logic         rd_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;

  modport master (
    input  rd_ready,
    output rd_valid,
    output rd_data
  );

  modport slave (
    output rd_ready,
    input  rd_valid,
    input  rd_data
  );
endinterface

// File: rtl/count_capture.sv
// count_capture: high-byte extension of count8_ld plus snapshot FIFO
// Optional macro COUNT_CAPTURE_OVWR_EN: a push into a full FIFO overwrites the oldest entry.
module count_capture #(
  parameter int DEPTH = 4,
  parameter int HI_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               q,
  input  logic                     co,
  input  logic                     cap,
  input  logic                     clr,
  count_capture_if.master          rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic [HI_W-1:0]          hi,
  output logic                     lost
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = HI_W + 8;

`ifdef COUNT_CAPTURE_OVWR_EN
  localparam bit OVWR = 1'b1;
`else
  localparam bit OVWR = 1'b0;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;

  logic full;
  logic empty;
  logic pop;
  logic ovf;
  logic wr_en;
  logic rd_adv;

  // Handshake and push/pop decisions from registered state only
  always_comb begin
    full   = (cnt == LW'(DEPTH));
    empty  = (cnt == '0);
    pop    = !empty && rd.rd_ready;
    ovf    = cap && full && !pop;
    wr_en  = cap && (!ovf || OVWR);
    rd_adv = pop || (ovf && OVWR);
  end

  // High counter driven by the counter carry; clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
    end else if (clr) begin
      hi <= '0;
    end else if (co) begin
      hi <= hi + HI_W'(1);
    end
  end

  // Snapshot storage; pre-edge {hi, q} is written
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= {hi, q};
    end
  end

  // Pointers, occupancy and sticky loss flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      lost   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_adv) begin
        cnt <= cnt + LW'(1);
      end else if (!wr_en && rd_adv) begin
        cnt <= cnt - LW'(1);
      end
      if (ovf) begin
        lost <= 1'b1;
      end
    end
  end

  assign level       = cnt;
  assign rd.rd_valid = !empty;
  assign rd.rd_data  = empty ? '0 : mem[rd_ptr];

endmodule
